text_buffer_ctrl: RTL and testbench
===================================

Name: text_buffer_ctrl

Overview:
Owns the character-code buffer that feeds the font ROM in front of the character-rendering stage. Arbitrates character writes from two requesters (A: game logic, B: menu/overlay) with round-robin fairness. Sequences a full-screen clear after reset or on command, gating the renderer's text enable while the clear runs. Serves the renderer's char_xy lookups with a registered read.

Parameters:
TEXT_SIZE_X, 16, text columns in use (1..16)
TEXT_SIZE_Y, 16, text rows in use (1..16)
BLANK_CHAR, 7'h20, code written by clear; returned for out-of-range reads

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
clear_req  in  1  single-cycle pulse; start a full clear
req_a  in  1  requester A write request; held until granted
addr_a  in  8  A target {column[3:0], row[3:0]}
data_a  in  7  A character code
gnt_a  out  1  one-cycle grant; A's write has been performed
req_b  in  1  requester B write request
addr_b  in  8  B target {column[3:0], row[3:0]}
data_b  in  7  B character code
gnt_b  out  1  one-cycle grant for B
char_xy  in  8  renderer lookup address {column[3:0], row[3:0]}
char_code  out  7  registered character code for char_xy
busy  out  1  clear in progress
text_en  out  1  renderer text enable; equals ~busy (registered)

Behaviour:
- One clock (clk); reset asynchronous, active-low (rst_n).
- Storage: 256 x 7 register array indexed by the 8-bit address. Not reset; contents are defined by the clear sequence.
- Reset values:
  - gnt_a = gnt_b = 0, char_code = 0, busy = 1, text_en = 0.
  - FSM = CLEAR, clr_cnt = 0, last_winner = B, so A wins the first tie.
- FSM states:
  - CLEAR: each cycle write BLANK_CHAR to mem[clr_cnt], then clr_cnt++. In the cycle clr_cnt = 255, go to IDLE, drop busy and raise text_en on that edge. Exactly 256 write cycles. No grants. clear_req is ignored.
  - IDLE: if clear_req = 1, go to CLEAR with clr_cnt = 0 and busy = 1 on the next edge; no grant that cycle (clear beats requests). Otherwise run the arbiter.
- Arbiter (IDLE only):
  - Eligible = req_x & ~gnt_x. A requester whose gnt is currently high is masked, so a held request is never written twice.
  - One eligible: it wins.
  - Both eligible: the one that is not last_winner wins.
  - On the edge: mem[addr_w] <= data_w, gnt_w <= 1 for exactly one cycle, last_winner <= w.
  - Max rate: one write per clock overall; one write per 2 clocks per requester.
- Range check:
  - A write with column >= TEXT_SIZE_X or row >= TEXT_SIZE_Y is dropped (no memory change) but is still granted and still updates last_winner.
  - Clear writes all 256 entries regardless of range.
- Read path:
  - char_code <= mem[char_xy] every clock; 1-cycle latency.
  - Out-of-range char_xy returns BLANK_CHAR.
  - Read and write to the same address on the same edge: char_code shows the old value; the new value is visible from the next read.
  - During CLEAR, reads return whatever is currently in memory; the renderer is gated by text_en = 0.
- Pending requests during CLEAR stay pending (req held, no gnt) and are arbitrated normally once IDLE.
- rst_n asserted mid-clear or mid-grant: outputs return to reset values immediately and the clear restarts from address 0 after release.

Test Plan:
- Reset release -> busy = 1 and text_en = 0 for exactly 256 cycles, then busy = 0 and text_en = 1; char_xy = 8'h00, 8'h5A and 8'hFF each give char_code = 7'h20 one cycle later.
- IDLE, req_a = 1, addr_a = 8'h12, data_a = 7'h41 -> gnt_a high for exactly one cycle after the next edge; then char_xy = 8'h12 gives char_code = 7'h41 next cycle; holding req_a through gnt causes no second write.
- req_a and req_b held continuously from reset-idle with distinct addresses/data -> grant order A, B, A, B, gnt one cycle wide each, all four writes visible on read-back.
- clear_req and req_a in the same IDLE cycle -> no gnt_a, busy = 1 next cycle, 256 clear cycles, then gnt_a on the first IDLE cycle; the written cell holds data_a and every other cell holds 7'h20.
- TEXT_SIZE_X = 10: write addr_a = 8'hC3, data 7'h55 -> gnt_a pulses; read of 8'hC3 returns 7'h20, and the earlier contents of in-range cells are unchanged.
- rst_n pulsed low at clear cycle 100 -> outputs at reset values asynchronously; after release busy stays high for a full 256 cycles.

Source files
------------

// File: rtl/text_buffer_ctrl.sv
// Character-code buffer feeding the font ROM.
// Two round-robin write requesters (A: game logic, B: menu/overlay), a
// full-screen clear sequencer that gates the renderer while it runs, and a
// registered single-cycle read port for the renderer's char_xy lookups.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_CLEAR | writing BLANK_CHAR to every cell, one per clock; busy high
//   ST_IDLE  | serving requester writes; clear_req restarts the clear
module text_buffer_ctrl #(
  parameter int unsigned TEXT_SIZE_X = 16,
  parameter int unsigned TEXT_SIZE_Y = 16,
  parameter logic [6:0]  BLANK_CHAR  = 7'h20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear_req,
  input  logic       req_a,
  input  logic [7:0] addr_a,
  input  logic [6:0] data_a,
  output logic       gnt_a,
  input  logic       req_b,
  input  logic [7:0] addr_b,
  input  logic [6:0] data_b,
  output logic       gnt_b,
  input  logic [7:0] char_xy,
  output logic [6:0] char_code,
  output logic       busy,
  output logic       text_en
);

  // Compared as 5-bit so a full 16-wide/high screen is representable.
  localparam logic [4:0] LIM_X = 5'(TEXT_SIZE_X);
  localparam logic [4:0] LIM_Y = 5'(TEXT_SIZE_Y);

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } state_e;

  state_e     state_q;
  logic [7:0] clr_cnt_q;
  logic       busy_q;
  logic       text_en_q;
  logic       gnt_a_q;
  logic       gnt_b_q;
  logic       last_b_q;     // 1: B won the most recent arbitration
  logic [6:0] char_code_q;
  logic [6:0] mem_q [256];

  logic       elig_a;
  logic       elig_b;
  logic       win_a;
  logic       win_b;
  logic       wr_en_d;
  logic [7:0] wr_addr_d;
  logic [6:0] wr_data_d;

  // Address is {column, row}; anything outside the used text area is inert.
  function automatic logic in_range(input logic [7:0] a);
    return ({1'b0, a[7:4]} < LIM_X) && ({1'b0, a[3:0]} < LIM_Y);
  endfunction

  // Round-robin arbitration; a requester whose grant is showing is masked so
  // a request still held during its grant cycle is not written twice.
  always_comb begin
    elig_a = req_a & ~gnt_a_q;
    elig_b = req_b & ~gnt_b_q;
    win_a  = 1'b0;
    win_b  = 1'b0;
    if ((state_q == ST_IDLE) && !clear_req) begin
      win_a = elig_a & (~elig_b | last_b_q);
      win_b = elig_b & (~elig_a | ~last_b_q);
    end
  end

  // Single write port: clear sweep has priority, then the arbiter winner.
  // Out-of-range requester writes are granted but never reach the array.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = clr_cnt_q;
    wr_data_d = BLANK_CHAR;
    if (state_q == ST_CLEAR) begin
      wr_en_d = 1'b1;
    end else if (win_a) begin
      wr_en_d   = in_range(addr_a);
      wr_addr_d = addr_a;
      wr_data_d = data_a;
    end else if (win_b) begin
      wr_en_d   = in_range(addr_b);
      wr_addr_d = addr_b;
      wr_data_d = data_b;
    end
  end

  // Clear/idle sequencer with registered grant, busy and text enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= 8'd0;
      busy_q    <= 1'b1;
      text_en_q <= 1'b0;
      gnt_a_q   <= 1'b0;
      gnt_b_q   <= 1'b0;
      last_b_q  <= 1'b1;
    end else begin
      gnt_a_q <= win_a;
      gnt_b_q <= win_b;
      case (state_q)
        ST_CLEAR: begin
          clr_cnt_q <= clr_cnt_q + 8'd1;
          if (clr_cnt_q == 8'hFF) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            text_en_q <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (clear_req) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= 8'd0;
            busy_q    <= 1'b1;
            text_en_q <= 1'b0;
          end else if (win_a) begin
            last_b_q <= 1'b0;
          end else if (win_b) begin
            last_b_q <= 1'b1;
          end
        end
      endcase
    end
  end

  // Character array; contents are defined only by the clear sweep and writes.
  always_ff @(posedge clk) begin
    if (wr_en_d) begin
      mem_q[wr_addr_d] <= wr_data_d;
    end
  end

  // Registered lookup; a same-edge write is seen on the following read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_code_q <= 7'd0;
    end else begin
      char_code_q <= in_range(char_xy) ? mem_q[char_xy] : BLANK_CHAR;
    end
  end

  assign gnt_a     = gnt_a_q;
  assign gnt_b     = gnt_b_q;
  assign char_code = char_code_q;
  assign busy      = busy_q;
  assign text_en   = text_en_q;

endmodule

// File: tb/tb_text_buffer_ctrl.sv
// Bench for text_buffer_ctrl: directed scenarios plus a randomized phase,
// all compared against a plain array model of the visible text buffer.
module tb_text_buffer_ctrl;

  localparam int unsigned TX    = 10;
  localparam int unsigned TY    = 16;
  localparam logic [6:0]  BLANK = 7'h20;

  logic       clk;
  logic       rst_n;
  logic       clear_req;
  logic       req_a, req_b;
  logic [7:0] addr_a, addr_b;
  logic [6:0] data_a, data_b;
  logic       gnt_a, gnt_b;
  logic [7:0] char_xy;
  logic [6:0] char_code;
  logic       busy, text_en;

  int checks = 0;
  int errors = 0;

  logic [6:0] model_mem [256];
  bit         model_last_b;

  text_buffer_ctrl #(
    .TEXT_SIZE_X(TX),
    .TEXT_SIZE_Y(TY),
    .BLANK_CHAR (BLANK)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_req(clear_req),
    .req_a    (req_a),
    .addr_a   (addr_a),
    .data_a   (data_a),
    .gnt_a    (gnt_a),
    .req_b    (req_b),
    .addr_b   (addr_b),
    .data_b   (data_b),
    .gnt_b    (gnt_b),
    .char_xy  (char_xy),
    .char_code(char_code),
    .busy     (busy),
    .text_en  (text_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit in_rng(input logic [7:0] a);
    return (int'(a[7:4]) < TX) && (int'(a[3:0]) < TY);
  endfunction

  function automatic logic [6:0] model_read(input logic [7:0] a);
    return in_rng(a) ? model_mem[a] : BLANK;
  endfunction

  task automatic model_write(input logic [7:0] a, input logic [6:0] d);
    if (in_rng(a)) model_mem[a] = d;
  endtask

  task automatic model_blank();
    for (int i = 0; i < 256; i++) model_mem[i] = BLANK;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic read_chk(input logic [7:0] a, input string tag);
    char_xy = a;
    @(negedge clk);
    check(tag, {25'd0, char_code}, {25'd0, model_read(a)});
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 256; i++) read_chk(8'(i), tag);
  endtask

  // Called at the negedge where busy is first expected high.
  task automatic wait_clear_done(input string tag);
    int cnt = 0;
    bit saw_en = 0;
    bit saw_gnt = 0;
    while (busy === 1'b1 && cnt < 400) begin
      cnt++;
      if (text_en !== 1'b0) saw_en = 1;
      if (gnt_a !== 1'b0 || gnt_b !== 1'b0) saw_gnt = 1;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, cnt, 256);
    check({tag, "_text_en_low"}, {31'd0, saw_en}, 0);
    check({tag, "_no_gnt"}, {31'd0, saw_gnt}, 0);
    check({tag, "_busy_end"}, {31'd0, busy}, 0);
    check({tag, "_text_en_end"}, {31'd0, text_en}, 1);
  endtask

  task automatic write_one(input bit is_b, input logic [7:0] a, input logic [6:0] d);
    if (is_b) begin
      req_b = 1'b1; addr_b = a; data_b = d;
    end else begin
      req_a = 1'b1; addr_a = a; data_a = d;
    end
    @(negedge clk);
    check("single_gnt_a", {31'd0, gnt_a}, {31'd0, !is_b});
    check("single_gnt_b", {31'd0, gnt_b}, {31'd0, is_b});
    req_a = 1'b0;
    req_b = 1'b0;
    model_write(a, d);
    model_last_b = is_b;
    @(negedge clk);
    check("single_gnt_width", {30'd0, gnt_a, gnt_b}, 0);
  endtask

  // Both request together; whoever did not win last goes first.
  task automatic write_both(input logic [7:0] aa, input logic [6:0] da,
                            input logic [7:0] ab, input logic [6:0] db);
    bit first_b;
    first_b = !model_last_b;
    req_a = 1'b1; addr_a = aa; data_a = da;
    req_b = 1'b1; addr_b = ab; data_b = db;
    @(negedge clk);
    check("both_first", {30'd0, gnt_a, gnt_b}, first_b ? 2'b01 : 2'b10);
    if (first_b) begin req_b = 1'b0; model_write(ab, db); end
    else begin req_a = 1'b0; model_write(aa, da); end
    @(negedge clk);
    check("both_second", {30'd0, gnt_a, gnt_b}, first_b ? 2'b10 : 2'b01);
    if (first_b) begin req_a = 1'b0; model_write(aa, da); end
    else begin req_b = 1'b0; model_write(ab, db); end
    model_last_b = !first_b;
    @(negedge clk);
    check("both_idle", {30'd0, gnt_a, gnt_b}, 0);
  endtask

  initial begin
    logic [7:0] alt_addr [4];
    logic [6:0] alt_data [4];
    logic [7:0] ra, rb;
    logic [6:0] rd_a, rd_b;
    logic [6:0] clr_data;
    int cnt;
    bit got;

    rst_n = 1'b0; clear_req = 1'b0;
    req_a = 1'b0; addr_a = 8'd0; data_a = 7'd0;
    req_b = 1'b0; addr_b = 8'd0; data_b = 7'd0;
    char_xy = 8'd0;
    model_last_b = 1'b1;

    // Reset values, then power-on clear.
    repeat (3) @(negedge clk);
    check("rst_gnt", {30'd0, gnt_a, gnt_b}, 0);
    check("rst_char_code", {25'd0, char_code}, 0);
    check("rst_busy", {31'd0, busy}, 1);
    check("rst_text_en", {31'd0, text_en}, 0);
    rst_n = 1'b1;
    wait_clear_done("por");
    model_blank();
    read_chk(8'h00, "por_rd_00");
    read_chk(8'h5A, "por_rd_5A");
    read_chk(8'hFF, "por_rd_FF");

    // Both requesters held from reset-idle: A, B, A, B.
    for (int i = 0; i < 4; i++) begin
      alt_addr[i] = {4'(i * 2 + int'($urandom_range(0, 1))), 4'($urandom_range(0, 15))};
      alt_data[i] = 7'($urandom_range(0, 127));
    end
    req_a = 1'b1; addr_a = alt_addr[0]; data_a = alt_data[0];
    req_b = 1'b1; addr_b = alt_addr[1]; data_b = alt_data[1];
    @(negedge clk);
    check("alt_0_A", {30'd0, gnt_a, gnt_b}, 2'b10);
    model_write(alt_addr[0], alt_data[0]);
    addr_a = alt_addr[2]; data_a = alt_data[2];
    @(negedge clk);
    check("alt_1_B", {30'd0, gnt_a, gnt_b}, 2'b01);
    model_write(alt_addr[1], alt_data[1]);
    addr_b = alt_addr[3]; data_b = alt_data[3];
    @(negedge clk);
    check("alt_2_A", {30'd0, gnt_a, gnt_b}, 2'b10);
    model_write(alt_addr[2], alt_data[2]);
    req_a = 1'b0;
    @(negedge clk);
    check("alt_3_B", {30'd0, gnt_a, gnt_b}, 2'b01);
    model_write(alt_addr[3], alt_data[3]);
    req_b = 1'b0;
    model_last_b = 1'b1;
    @(negedge clk);
    check("alt_idle", {30'd0, gnt_a, gnt_b}, 0);
    for (int i = 0; i < 4; i++) read_chk(alt_addr[i], "alt_rd");

    // Request held through its grant must not be written a second time.
    req_a = 1'b1; addr_a = 8'h12; data_a = 7'h41;
    @(negedge clk);
    check("hold_gnt", {31'd0, gnt_a}, 1);
    data_a = 7'h7F;
    @(negedge clk);
    check("hold_gnt_drop", {31'd0, gnt_a}, 0);
    req_a = 1'b0;
    model_write(8'h12, 7'h41);
    model_last_b = 1'b0;
    @(negedge clk);
    check("hold_no_regnt", {31'd0, gnt_a}, 0);
    read_chk(8'h12, "hold_rd_12");

    // Column 12 is beyond the 10 used columns: granted, not stored.
    write_one(1'b0, 8'hC3, 7'h55);
    read_chk(8'hC3, "range_rd_C3");
    read_chk(8'h12, "range_keep_12");
    for (int i = 0; i < 4; i++) read_chk(alt_addr[i], "range_keep");

    // Randomized mix of writes and reads.
    for (int it = 0; it < 60; it++) begin
      ra = 8'($urandom_range(0, 255)); rb = 8'($urandom_range(0, 255));
      rd_a = 7'($urandom_range(0, 127)); rd_b = 7'($urandom_range(0, 127));
      case ($urandom_range(0, 3))
        0: write_one(1'b0, ra, rd_a);
        1: write_one(1'b1, rb, rd_b);
        2: write_both(ra, rd_a, rb, rd_b);
        default: read_chk(ra, "rand_rd");
      endcase
    end
    sweep("rand_sweep");

    // Clear beats a same-cycle request; the request is served afterwards.
    clr_data = 7'h41 + 7'($urandom_range(0, 15));
    clear_req = 1'b1;
    req_a = 1'b1; addr_a = 8'h9F; data_a = clr_data;
    @(negedge clk);
    clear_req = 1'b0;
    check("clr_no_gnt", {31'd0, gnt_a}, 0);
    check("clr_busy", {31'd0, busy}, 1);
    wait_clear_done("clr");
    check("clr_pending_not_yet", {31'd0, gnt_a}, 0);
    got = 0;
    cnt = 0;
    while (!got && cnt < 4) begin
      @(negedge clk);
      cnt++;
      got = (gnt_a === 1'b1);
    end
    check("clr_pending_gnt_latency", cnt, 1);
    req_a = 1'b0;
    model_blank();
    model_write(8'h9F, clr_data);
    model_last_b = 1'b0;
    sweep("clr_sweep");

    // Reset in the middle of a clear restarts it from scratch.
    char_xy = 8'h9F;
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    repeat (100) @(negedge clk);
    check("mid_pre_char", {25'd0, char_code}, {25'd0, clr_data});
    check("mid_pre_busy", {31'd0, busy}, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_char", {25'd0, char_code}, 0);
    check("mid_rst_busy", {31'd0, busy}, 1);
    check("mid_rst_text_en", {31'd0, text_en}, 0);
    check("mid_rst_gnt", {30'd0, gnt_a, gnt_b}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_clear_done("mid");
    model_blank();
    model_last_b = 1'b1;
    sweep("mid_sweep");
    write_both(8'h45, 7'h11, 8'h46, 7'h22);
    read_chk(8'h45, "post_rd_45");
    read_chk(8'h46, "post_rd_46");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
